fetch_queue_stage: RTL

Parametrised successor of the single-cycle variable-length fetch stage. It issues aligned FETCH_BYTES-wide block requests to instruction memory over a valid/ready request channel and a fixed-order response channel. Returned bytes go into a byte queue. The block decodes the length of the instruction at the queue head and presents whole instructions (1–5 bytes, little-endian) to decode with a valid/ready handshake. It sits between instruction memory and decode, and takes redirects from execute.

---
 rtl/fetch_queue_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue_stage.sv
// Variable-length fetch stage: block requests to instruction memory, byte queue,
// and head-of-queue length decode presenting whole instructions to decode.
module fetch_queue_stage #(
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned QUEUE_BYTES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [8*FETCH_BYTES-1:0] imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [39:0]              out_instr,
  output logic [2:0]               out_length,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_next_pc,
  output logic                     halted
);

  localparam int unsigned SW = $clog2(FETCH_BYTES);
  localparam int unsigned PW = $clog2(QUEUE_BYTES);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] ALIGN_MASK = ~(32'(FETCH_BYTES) - 32'd1);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    q_q [QUEUE_BYTES];
  logic [7:0]    q_d [QUEUE_BYTES];

  logic [7:0]    head_c;
  logic [2:0]    dec_len_c;
  logic [2:0]    len_c;
  logic [CW-1:0] free_c;
  logic [CW-1:0] push_cnt_c;
  logic          push_c;
  logic          fire_c;

  // Length decode of the opcode at the queue head
  assign head_c = q_q[rd_ptr_q];
  always_comb begin
    dec_len_c = 3'd1;
    case (head_c)
      8'h01, 8'h89:               dec_len_c = 3'd2;
      8'h83:                      dec_len_c = 3'd3;
      8'hB8, 8'hB9, 8'h05, 8'hE9: dec_len_c = 3'd5;
      default:                    dec_len_c = 3'd1;
    endcase
  end

  assign len_c      = (count_q != '0) ? dec_len_c : 3'd0;
  assign free_c     = CW'(QUEUE_BYTES) - count_q;
  assign push_cnt_c = CW'(FETCH_BYTES) - CW'(skip_q);

  assign out_valid = (count_q != '0) && (count_q >= CW'(len_c)) && !redirect_valid
                     && (state_q != S_HALT);
  assign fire_c    = out_valid && out_ready;
  // Request is withdrawn during redirect so a stale block is never launched
  assign imem_req_valid = !rst && (state_q == S_REQ) && (free_c >= CW'(FETCH_BYTES))
                          && !redirect_valid;
  assign push_c    = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;

  assign imem_req_addr = fetch_addr_q;
  assign out_pc        = out_pc_q;
  assign out_length    = len_c;
  assign out_next_pc   = out_pc_q + 32'(len_c);
  assign halted        = (state_q == S_HALT);

  // Instruction bytes beyond the decoded length read as zero
  always_comb begin
    out_instr = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (3'(i) < len_c) out_instr[8*i +: 8] = q_q[rd_ptr_q + PW'(i)];
    end
  end

  // Next-state: redirect beats fire and push; HALT is sticky until reset
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    skip_d       = skip_q;
    out_pc_d     = out_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    q_d          = q_q;
    if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (redirect_valid) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      out_pc_d     = redirect_pc;
      fetch_addr_d = redirect_pc & ALIGN_MASK;
      skip_d       = redirect_pc[SW-1:0];
      state_d      = (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_resp_valid)
                     ? S_DRAIN : S_REQ;
    end else begin
      case (state_q)
        S_REQ:   if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
        S_WAIT:  if (imem_resp_valid) begin
                   skip_d       = '0;
                   fetch_addr_d = fetch_addr_q + 32'(FETCH_BYTES);
                   state_d      = S_REQ;
                 end
        S_DRAIN: if (imem_resp_valid) state_d = S_REQ;
        default: state_d = state_q;
      endcase
      if (push_c) begin
        for (int unsigned i = 0; i < FETCH_BYTES; i++) begin
          if (SW'(i) >= skip_q) q_d[wr_ptr_q + PW'(i) - PW'(skip_q)] = imem_resp_data[8*i +: 8];
        end
        wr_ptr_d = wr_ptr_q + PW'(push_cnt_c);
      end
      if (fire_c) begin
        rd_ptr_d = rd_ptr_q + PW'(len_c);
        out_pc_d = out_pc_q + 32'(len_c);
        if (head_c == 8'hF4) state_d = S_HALT;
      end
      count_d = count_q + (push_c ? push_cnt_c : CW'(0)) - (fire_c ? CW'(len_c) : CW'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      fetch_addr_q <= RESET_PC & ALIGN_MASK;
      skip_q       <= RESET_PC[SW-1:0];
      out_pc_q     <= RESET_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      skip_q       <= skip_d;
      out_pc_q     <= out_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Queue storage is pure datapath; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

endmodule
